uart_rx_frame_ctrl: RTL and testbench

- Sequences the byte-level UART receiver.
- Holds the receiver's enable, consumes its per-byte done pulse and data, and parses framed packets: header bytes, length byte, payload, checksum.
- Streams validated payload bytes to downstream video/control logic and reports per-frame OK/error status plus running counters.
- Sits directly above the UART receive path in the uart/rx hierarchy.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_frame_ctrl_if.sv | 30 +++
 rtl/frame_stat_cnt.sv | 32 +++
 rtl/uart_rx_frame_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART frame receive controller.
//   state_t      : frame parser FSM state encoding (3 bits)
//   ERR_*        : values carried on err_code
//   HDR*_DEFAULT : default sync bytes
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC0   = 3'd1,
    ST_SYNC1   = 3'd2,
    ST_LEN     = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CSUM    = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] HDR0_DEFAULT = 8'hAA;
  localparam logic [7:0] HDR1_DEFAULT = 8'h55;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: bundles the control, byte-receiver and payload/status
// signals of the frame receive controller.
//   slave  : controller side (ctrl_en, rx_done_signal, rx_data in; rest out)
//   master : environment side (mirror of slave)
interface uart_rx_frame_ctrl_if;
  logic        ctrl_en;
  logic        rx_done_signal;
  logic [7:0]  rx_data;
  logic        rx_enable_signal;
  logic [7:0]  pay_data;
  logic        pay_valid;
  logic        pay_last;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;

  modport slave (
    input  ctrl_en, rx_done_signal, rx_data,
    output rx_enable_signal, pay_data, pay_valid, pay_last,
           frame_ok, frame_err, err_code, ok_cnt, err_cnt
  );

  modport master (
    output ctrl_en, rx_done_signal, rx_data,
    input  rx_enable_signal, pay_data, pay_valid, pay_last,
           frame_ok, frame_err, err_code, ok_cnt, err_cnt
  );
endinterface

// File: rtl/frame_stat_cnt.sv
// frame_stat_cnt: per-frame statistics counters.
//   clk, rst (async, active-low)
//   i_ok      : good-frame pulse  -> o_ok_cnt increments, wraps
//   i_err     : bad-frame pulse   -> o_err_cnt increments, saturates at FFFF
module frame_stat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ok,
  input  logic        i_err,
  output logic [15:0] o_ok_cnt,
  output logic [15:0] o_err_cnt
);

  logic [15:0] r_ok_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ok_cnt  <= 16'd0;
      r_err_cnt <= 16'd0;
    end else begin
      if (i_ok)
        r_ok_cnt <= r_ok_cnt + 16'd1;
      if (i_err && (r_err_cnt != 16'hFFFF))
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign o_ok_cnt  = r_ok_cnt;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: enables the byte receiver and parses framed packets
//   HDR0 HDR1 LEN payload[LEN] CSUM   (CSUM = LEN + sum(payload), mod 256)
// Payload bytes stream out one cycle after their rx_done_signal, before the
// checksum is known; downstream drops them on frame_err.
//   clk, rst (async, active-low)
//   bus.ctrl_en, bus.rx_done_signal, bus.rx_data           : inputs
//   bus.rx_enable_signal, bus.pay_*, bus.frame_ok/_err,
//   bus.err_code, bus.ok_cnt, bus.err_cnt                  : outputs
// Optional build macro RX_TIMEOUT_EN adds an inter-byte timeout in
// LEN/PAYLOAD/CSUM (err_code 3).
//
// state      | meaning
// IDLE       | receiver disabled, waiting for ctrl_en
// SYNC0      | hunting for first sync byte
// SYNC1      | first sync byte seen, expecting second
// LEN        | expecting length byte
// PAYLOAD    | streaming payload bytes
// CSUM       | expecting checksum byte
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] HDR0    = HDR0_DEFAULT,
  parameter logic [7:0] HDR1    = HDR1_DEFAULT,
  parameter int         MAX_LEN = 64
`ifdef RX_TIMEOUT_EN
  , parameter int       TIMEOUT_CYC = 5000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_frame_ctrl_if.slave   bus
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t      r_state;
  logic        r_rx_en;
  logic [7:0]  r_pay_data;
  logic        r_pay_valid;
  logic        r_pay_last;
  logic        r_frame_ok;
  logic        r_frame_err;
  logic [1:0]  r_err_code;
  logic [7:0]  r_len;
  logic [7:0]  r_idx;
  logic [7:0]  r_csum;
  logic [15:0] w_ok_cnt;
  logic [15:0] w_err_cnt;

  logic       w_done;
  logic [7:0] w_byte;
  logic       w_len_bad;

  assign w_done    = bus.rx_done_signal;
  assign w_byte    = bus.rx_data;
  assign w_len_bad = (w_byte == 8'd0) || (w_byte > MAX_LEN_B);

`ifdef RX_TIMEOUT_EN
  logic [15:0] r_idle_cnt;
  logic        w_timed;
  logic        w_expire;

  assign w_timed  = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) ||
                    (r_state == ST_CSUM);
  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign w_expire = w_timed && !w_done && (r_idle_cnt == 16'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_rx_en     <= 1'b0;
      r_pay_data  <= 8'd0;
      r_pay_valid <= 1'b0;
      r_pay_last  <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_len       <= 8'd0;
      r_idx       <= 8'd0;
      r_csum      <= 8'd0;
`ifdef RX_TIMEOUT_EN
      r_idle_cnt  <= 16'd0;
`endif
    end else begin
      r_pay_valid <= 1'b0;
      r_pay_last  <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef RX_TIMEOUT_EN
      r_idle_cnt  <= (w_timed && !w_done) ? r_idle_cnt + 16'd1 : 16'd0;
`endif
      if (!bus.ctrl_en) begin
        // Disable drops any partial frame without reporting it.
        r_state <= ST_IDLE;
        r_rx_en <= 1'b0;
        r_len   <= 8'd0;
        r_idx   <= 8'd0;
        r_csum  <= 8'd0;
`ifdef RX_TIMEOUT_EN
        r_idle_cnt <= 16'd0;
      end else if (w_expire) begin
        r_frame_err <= 1'b1;
        r_err_code  <= ERR_TIMEOUT;
        r_state     <= ST_SYNC0;
        r_len       <= 8'd0;
        r_idx       <= 8'd0;
        r_csum      <= 8'd0;
        r_idle_cnt  <= 16'd0;
`endif
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_state <= ST_SYNC0;
            r_rx_en <= 1'b1;
          end
          ST_SYNC0: begin
            if (w_done && (w_byte == HDR0))
              r_state <= ST_SYNC1;
          end
          ST_SYNC1: begin
            if (w_done) begin
              if (w_byte == HDR1)
                r_state <= ST_LEN;
              else if (w_byte != HDR0)
                r_state <= ST_SYNC0;
            end
          end
          ST_LEN: begin
            if (w_done) begin
              if (w_len_bad) begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_LEN;
                r_state     <= ST_SYNC0;
              end else begin
                r_len   <= w_byte;
                r_csum  <= w_byte;
                r_idx   <= 8'd0;
                r_state <= ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            if (w_done) begin
              r_pay_data  <= w_byte;
              r_pay_valid <= 1'b1;
              r_csum      <= r_csum + w_byte;
              r_idx       <= r_idx + 8'd1;
              if ((r_idx + 8'd1) == r_len) begin
                r_pay_last <= 1'b1;
                r_state    <= ST_CSUM;
              end
            end
          end
          ST_CSUM: begin
            if (w_done) begin
              if (w_byte == r_csum) begin
                r_frame_ok <= 1'b1;
                r_err_code <= ERR_NONE;
              end else begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_CSUM;
              end
              r_state <= ST_SYNC0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_rx_en <= 1'b0;
          end
        endcase
      end
    end
  end

  frame_stat_cnt u_stat (
    .clk      (clk),
    .rst      (rst),
    .i_ok     (r_frame_ok),
    .i_err    (r_frame_err),
    .o_ok_cnt (w_ok_cnt),
    .o_err_cnt(w_err_cnt)
  );

  assign bus.rx_enable_signal = r_rx_en;
  assign bus.pay_data         = r_pay_data;
  assign bus.pay_valid        = r_pay_valid;
  assign bus.pay_last         = r_pay_last;
  assign bus.frame_ok         = r_frame_ok;
  assign bus.frame_err        = r_frame_err;
  assign bus.err_code         = r_err_code;
  assign bus.ok_cnt           = w_ok_cnt;
  assign bus.err_cnt          = w_err_cnt;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: self-checking bench for uart_rx_frame_ctrl.
// Byte streams are parsed by a sequential scanning model to produce the
// expected payload and status sequences; the DUT's outputs are collected by a
// monitor and compared. Build with +define+RX_TIMEOUT_EN to check the timeout.
module tb_uart_rx_frame_ctrl;
  import uart_pkg::*;

  localparam int         MAX_LEN     = 64;
  localparam int         TIMEOUT_CYC = 5000;
  localparam logic [7:0] HDR0        = 8'hAA;
  localparam logic [7:0] HDR1        = 8'h55;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_frame_ctrl_if bus ();

  uart_rx_frame_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic        sat_ok  = 1'b0;
  logic        sat_err = 1'b0;
  logic [15:0] sat_ok_cnt;
  logic [15:0] sat_err_cnt;

  frame_stat_cnt u_sat (
    .clk      (clk),
    .rst      (rst),
    .i_ok     (sat_ok),
    .i_err    (sat_err),
    .o_ok_cnt (sat_ok_cnt),
    .o_err_cnt(sat_err_cnt)
  );

  int checks   = 0;
  int failures = 0;
  int exp_ok   = 0;
  int exp_err  = 0;
  int n_status = 0;
  int lat_err  = 0;
  bit mon_en   = 1'b0;
  bit prev_done = 1'b0;

  logic [8:0] exp_pay[$];
  logic [8:0] act_pay[$];
  int         exp_st[$];
  int         act_st[$];

  // Status codes in the queues: 0 = frame_ok, otherwise the error code.
  always @(negedge clk) begin
    if (bus.frame_ok || bus.frame_err)
      n_status++;
    if (mon_en) begin
      if (bus.pay_valid) begin
        act_pay.push_back({bus.pay_last, bus.pay_data});
        if (!prev_done) lat_err++;
      end
      if (bus.frame_ok || bus.frame_err) begin
        act_st.push_back(bus.frame_ok ? 0 : int'(bus.err_code));
        if (!prev_done) lat_err++;
      end
      if (bus.frame_ok && bus.frame_err) lat_err++;
      prev_done = bus.rx_done_signal;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data        = b;
    bus.rx_done_signal = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_done_signal = 1'b0;
    bus.rx_data        = 8'($urandom);
  endtask

  task automatic model_stream(input logic [7:0] bq[$]);
    int   i;
    int   n;
    int   len;
    int   sum;
    logic lastb;
    exp_pay.delete();
    exp_st.delete();
    n = bq.size();
    i = 0;
    while (i < n) begin
      if (bq[i] != HDR0) begin
        i++;
        continue;
      end
      i++;
      while (i < n && bq[i] == HDR0) i++;
      if (i >= n) break;
      if (bq[i] != HDR1) begin
        i++;
        continue;
      end
      i++;
      if (i >= n) break;
      len = int'(bq[i]);
      i++;
      if (len == 0 || len > MAX_LEN) begin
        exp_st.push_back(1);
        continue;
      end
      sum = len;
      for (int k = 0; k < len && i < n; k++) begin
        lastb = (k == len - 1);
        exp_pay.push_back({lastb, bq[i]});
        sum += int'(bq[i]);
        i++;
      end
      if (i >= n) break;
      exp_st.push_back(((sum % 256) == int'(bq[i])) ? 0 : 2);
      i++;
    end
  endtask

  task automatic run_stream(input logic [7:0] bq[$], input int max_gap, input string name);
    model_stream(bq);
    act_pay.delete();
    act_st.delete();
    lat_err = 0;
    mon_en  = 1'b1;
    foreach (bq[j]) begin
      send_byte(bq[j]);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
    idle(3);
    mon_en = 1'b0;

    checks++;
    if (act_pay.size() != exp_pay.size()) begin
      failures++;
      $display("FAIL %s payload count: got %0d want %0d", name, act_pay.size(), exp_pay.size());
    end else begin
      foreach (exp_pay[k]) begin
        checks++;
        if (act_pay[k] !== exp_pay[k]) begin
          failures++;
          $display("FAIL %s payload[%0d] {last,data}: got %h want %h", name, k, act_pay[k], exp_pay[k]);
        end
      end
    end
    checks++;
    if (act_st.size() != exp_st.size()) begin
      failures++;
      $display("FAIL %s status count: got %0d want %0d", name, act_st.size(), exp_st.size());
    end else begin
      foreach (exp_st[k]) begin
        checks++;
        if (act_st[k] != exp_st[k]) begin
          failures++;
          $display("FAIL %s status[%0d]: got %0d want %0d", name, k, act_st[k], exp_st[k]);
        end
      end
    end
    checks++;
    if (lat_err != 0) begin
      failures++;
      $display("FAIL %s latency: got %0d late/early strobes want 0", name, lat_err);
    end
    foreach (exp_st[k]) begin
      if (exp_st[k] == 0) exp_ok++;
      else if (exp_err < 65535) exp_err++;
    end
    checks++;
    if (bus.ok_cnt !== 16'(exp_ok)) begin
      failures++;
      $display("FAIL %s ok_cnt: got %0d want %0d", name, bus.ok_cnt, exp_ok);
    end
    checks++;
    if (bus.err_cnt !== 16'(exp_err)) begin
      failures++;
      $display("FAIL %s err_cnt: got %0d want %0d", name, bus.err_cnt, exp_err);
    end
    if (exp_st.size() > 0) begin
      checks++;
      if (bus.err_code !== 2'(exp_st[exp_st.size() - 1])) begin
        failures++;
        $display("FAIL %s err_code held: got %0d want %0d", name, bus.err_code, exp_st[exp_st.size() - 1]);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [46:0] v;
    v = {bus.rx_enable_signal, bus.pay_valid, bus.pay_last, bus.frame_ok, bus.frame_err,
         bus.err_code, bus.pay_data, bus.ok_cnt, bus.err_cnt};
    checks++;
    if (v !== 47'd0) begin
      failures++;
      $display("FAIL %s outputs: got %h want 0", name, v);
    end
    checks++;
    if (dut.r_state !== ST_IDLE) begin
      failures++;
      $display("FAIL %s state: got %0d want IDLE", name, dut.r_state);
    end
  endtask

  task automatic test_reset();
    bus.ctrl_en = 1'b1;
    idle(1);
    check_all_zero("reset");
    bus.ctrl_en = 1'b0;
    rst = 1'b1;
    idle(2);
    checks++;
    if (bus.rx_enable_signal !== 1'b0) begin
      failures++;
      $display("FAIL rx_enable disabled: got %b want 0", bus.rx_enable_signal);
    end
    bus.ctrl_en = 1'b1;
    idle(1);
    checks++;
    if (bus.rx_enable_signal !== 1'b1) begin
      failures++;
      $display("FAIL rx_enable enabled: got %b want 1", bus.rx_enable_signal);
    end
    idle(1);
  endtask

  task automatic test_good_frame();
    logic [7:0] q[$];
    q = {8'hAA, 8'h55, 8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
    run_stream(q, 0, "good_frame");
    checks++;
    if (bus.ok_cnt !== 16'd1 || bus.err_code !== 2'd0) begin
      failures++;
      $display("FAIL good_frame literal: got ok_cnt=%0d err_code=%0d want 1/0", bus.ok_cnt, bus.err_code);
    end
    checks++;
    if (act_pay.size() != 3 || act_pay[2] !== 9'h130) begin
      failures++;
      $display("FAIL good_frame last byte: got n=%0d want 3 with last {1,30}", act_pay.size());
    end
  endtask

  task automatic test_bad_csum();
    logic [7:0] q[$];
    q = {8'hAA, 8'h55, 8'h03, 8'h10, 8'h20, 8'h30, 8'h64};
    run_stream(q, 2, "bad_csum");
    checks++;
    if (bus.err_code !== 2'd2 || bus.err_cnt !== 16'd1 || act_pay.size() != 3) begin
      failures++;
      $display("FAIL bad_csum literal: got err_code=%0d err_cnt=%0d npay=%0d want 2/1/3",
               bus.err_code, bus.err_cnt, act_pay.size());
    end
  endtask

  task automatic test_len_resync();
    logic [7:0] q[$];
    q = {8'hAA, 8'hAA, 8'h55, 8'h00, 8'hAA, 8'h55, 8'h01, 8'h7F, 8'h80};
    run_stream(q, 1, "len_resync");
    checks++;
    if (act_st.size() != 2 || act_st[0] != 1 || act_st[1] != 0) begin
      failures++;
      $display("FAIL len_resync literal: got %0d statuses want [1,0]", act_st.size());
    end
  endtask

  task automatic test_len_bounds();
    logic [7:0] q[$];
    int         s;
    q = {8'hAA, 8'h55, 8'd64};
    s = 64;
    for (int k = 0; k < 64; k++) begin
      q.push_back(8'(k * 3 + 1));
      s += k * 3 + 1;
    end
    q.push_back(8'(s % 256));
    q = {q, 8'hAA, 8'h55, 8'd65, 8'hAA, 8'h55, 8'hFF};
    run_stream(q, 0, "len_bounds");
  endtask

  task automatic test_ctrl_drop();
    logic [7:0] q[$];
    int         s0;
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h02);
    send_byte(8'h11);
    bus.ctrl_en = 1'b0;
    s0 = n_status;
    idle(1);
    checks++;
    if (bus.rx_enable_signal !== 1'b0 || dut.r_state !== ST_IDLE) begin
      failures++;
      $display("FAIL ctrl_drop disable: got rx_en=%b state=%0d want 0/IDLE", bus.rx_enable_signal, dut.r_state);
    end
    idle(5);
    checks++;
    if (n_status != s0) begin
      failures++;
      $display("FAIL ctrl_drop silent: got %0d status pulses want 0", n_status - s0);
    end
    bus.ctrl_en = 1'b1;
    idle(2);
    q = {8'hAA, 8'h55, 8'h02, 8'h01, 8'h02, 8'h05};
    run_stream(q, 0, "ctrl_reenable");
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    q = {8'hAA, 8'h55, 8'h01, 8'h42, 8'h43, 8'hAA, 8'h55, 8'h02, 8'hF0, 8'h0F, 8'h01,
         8'hAA, 8'h55, 8'h01, 8'h00, 8'h02};
    run_stream(q, 0, "back_to_back");
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] b;
    int         kind;
    int         len;
    int         s;
    for (int f = 0; f < 30; f++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == HDR1) b = 8'h00;
        q.push_back(b);
      end
      if ($urandom_range(0, 3) == 0) q.push_back(HDR0);
      q.push_back(HDR0);
      q.push_back(HDR1);
      kind = int'($urandom_range(0, 3));
      if (kind == 3) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 255));
        q.push_back(8'(len));
      end else begin
        len = int'($urandom_range(1, 8));
        q.push_back(8'(len));
        s = len;
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom);
          q.push_back(b);
          s += int'(b);
        end
        if (kind == 2) q.push_back(8'((s + int'($urandom_range(1, 255))) % 256));
        else q.push_back(8'(s % 256));
      end
    end
    run_stream(q, 3, "random");
  endtask

`ifdef RX_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bit found;
    int s0;
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h02);
    send_byte(8'h11);
    n = 0;
    found = 1'b0;
    while (!found && n < 2 * TIMEOUT_CYC) begin
      @(negedge clk);
      n++;
      if (bus.frame_err) found = 1'b1;
    end
    checks++;
    if (!found || n != TIMEOUT_CYC + 1) begin
      failures++;
      $display("FAIL timeout timing: got found=%0d at %0d want at %0d", found, n, TIMEOUT_CYC + 1);
    end
    checks++;
    if (bus.err_code !== ERR_TIMEOUT) begin
      failures++;
      $display("FAIL timeout err_code: got %0d want 3", bus.err_code);
    end
    @(posedge clk);
    #1;
    exp_err++;
    checks++;
    if (bus.err_cnt !== 16'(exp_err)) begin
      failures++;
      $display("FAIL timeout err_cnt: got %0d want %0d", bus.err_cnt, exp_err);
    end
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h02);
    send_byte(8'h11);
    s0 = n_status;
    idle(TIMEOUT_CYC - 1);
    send_byte(8'h22);
    idle(2);
    checks++;
    if (n_status != s0) begin
      failures++;
      $display("FAIL timeout byte_wins: got %0d status pulses want 0", n_status - s0);
    end
    send_byte(8'h35);
    idle(2);
    exp_ok++;
    checks++;
    if (bus.ok_cnt !== 16'(exp_ok) || bus.err_code !== ERR_NONE) begin
      failures++;
      $display("FAIL timeout recover: got ok_cnt=%0d err_code=%0d want %0d/0", bus.ok_cnt, bus.err_code, exp_ok);
    end
  endtask
`else
  task automatic test_no_timeout();
    int s0;
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h02);
    send_byte(8'h11);
    s0 = n_status;
    idle(TIMEOUT_CYC + 20);
    checks++;
    if (n_status != s0 || bus.err_code === ERR_TIMEOUT) begin
      failures++;
      $display("FAIL no_timeout stall: got %0d pulses err_code=%0d want 0 pulses", n_status - s0, bus.err_code);
    end
    send_byte(8'h22);
    send_byte(8'h35);
    idle(2);
    exp_ok++;
    checks++;
    if (bus.ok_cnt !== 16'(exp_ok)) begin
      failures++;
      $display("FAIL no_timeout resume: got ok_cnt=%0d want %0d", bus.ok_cnt, exp_ok);
    end
  endtask
`endif

  task automatic test_reset_mid_payload();
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h02);
    checks++;
    if (bus.pay_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset pre: got pay_valid=%b want 1", bus.pay_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_ok  = 0;
    exp_err = 0;
    idle(1);
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_err_saturation();
    sat_ok  = 1'b1;
    sat_err = 1'b1;
    idle(65535);
    checks++;
    if (sat_ok_cnt !== 16'hFFFF || sat_err_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat at FFFF: got ok=%h err=%h want FFFF/FFFF", sat_ok_cnt, sat_err_cnt);
    end
    idle(1);
    sat_ok  = 1'b0;
    sat_err = 1'b0;
    checks++;
    if (sat_ok_cnt !== 16'h0000 || sat_err_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat wrap: got ok=%h err=%h want 0000/FFFF", sat_ok_cnt, sat_err_cnt);
    end
  endtask

  initial begin
    bus.ctrl_en        = 1'b0;
    bus.rx_done_signal = 1'b0;
    bus.rx_data        = 8'h00;
    rst                = 1'b0;
    #1;
    idle(2);
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len_resync();
    test_len_bounds();
    test_ctrl_drop();
    test_back_to_back();
    test_random();
`ifdef RX_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_payload();
    test_err_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
